dm_arbiter: RTL
===============

# dm_arbiter

Two-port arbiter and access sequencer for the 2048×16 data memory in the accumulator CPU. It shares the single memory port between the CPU datapath (port 0) and a debug/loader requester (port 1). For each granted access it drives the memory's read or write strobe, address and write data for exactly one cycle, then captures the result and acknowledges the winning requester. All memory-side outputs are registered, so the memory sees glitch-free strobes.

## Interface
- AW, 11, address width (data memory depth 2^AW words)
- DW, 16, data width
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 (CPU) always wins ties

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  port 0 request; held with cpu_we/addr/wdata stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  word address
- cpu_wdata  in  DW  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  last read data returned to port 0
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  same as port 0, for port 1
- mem_rd  out  1  memory read strobe (RdRam)
- mem_wr  out  1  memory write strobe (WrRam)
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; combinational from mem_addr/mem_rd
- busy  out  1  high in ACCESS and ACK states
- grant_id  out  1  port currently or most recently granted

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE: when any req is high at a rising edge, select a winner, latch its we/addr/wdata into mem_* registers, assert mem_rd (we=0) or mem_wr (we=1), set grant_id, and go to ACCESS. With no req, stay in IDLE.
- Selection: only one req high → that port wins. Both high → FIXED_PRIO=1: port 0 wins; FIXED_PRIO=0: the port that is not grant_id wins.
- ACCESS: one cycle with the strobe active. At the next edge, capture mem_rdata into the winner's rdata (reads only), deassert the strobe, pulse the winner's ack, and go to ACK.
- ACK: winner's ack is high for this single cycle. At the next edge, clear ack and go to IDLE. req values are ignored during ACCESS and ACK.
- Requester contract: on the edge where it sees ack high, a requester either drops req or presents its next request. The arbiter samples the new value in IDLE, so the same request is never serviced twice.
- Write accesses leave rdata unchanged. Each port's rdata holds its value until that port's next read completes.
- mem_addr and mem_wdata hold their last values outside ACCESS. Only the strobes return to 0.
- Only one of mem_rd/mem_wr is ever high, and only in ACCESS.

## Timing
- Reset (async, immediate on rst_n low): state=IDLE, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0, cpu_ack=dbg_ack=0, cpu_rdata=dbg_rdata=0, busy=0, grant_id=1 (so port 0 wins the first tie under round-robin).
- Latency: req sampled at edge E0 → strobe high in cycle E0..E1 → ack high in cycle E1..E2. rdata is valid from E1 and is stable whenever ack is high.
- Throughput: one access per 3 cycles. Two saturating requesters alternate 0,1,0,1 under round-robin.
- FIXED_PRIO=1 with cpu_req held continuously: port 1 starves. This is the intended behaviour.
- Reset asserted mid-ACCESS: strobes drop immediately and no ack is issued. A write in flight may or may not have landed, and the requester must reissue. Reset during ACK cancels the ack pulse.
- A req that drops before it is granted is simply lost; there is no error flag.

## Test plan
- Reset values: hold rst_n=0 while driving random req inputs → all outputs at their reset values, grant_id=1, no strobe. Release → idle with req=0.
- Single write/read: port 0 writes 0xBEEF to address 0x005, then reads address 0x005 → mem_wr high for exactly one cycle with mem_addr=0x005, cpu_ack 2 cycles after grant. The read returns cpu_rdata=0xBEEF with cpu_ack and leaves dbg_rdata=0.
- Tie, round-robin: both ports request reads of 0x010 and 0x7FF simultaneously from reset → port 0 is served first, then port 1. Acks are 3 cycles apart and grant_id goes 0 then 1.
- Back-to-back saturation: both req held for 4 accesses each → grants strictly alternate, every access takes 3 cycles, and each port's ack count equals 4.
- FIXED_PRIO=1: both req held with port 0 issuing 3 requests → port 1 receives no grant until cpu_req drops, then is granted in the next IDLE.
- Reset mid-write: pull rst_n low during the ACCESS cycle of a dbg write → mem_wr falls immediately and dbg_ack never pulses. After release, the reissued write completes normally.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between the CPU datapath
// (port 0) and the debug/loader requester (port 1). Each granted access runs
// IDLE (sample and grant) -> ACCESS (one strobe cycle) -> ACK (one ack cycle).
// Every memory-side and requester-side output comes straight from a flop.
module dm_arbiter #(
    parameter int AW         = 11,
    parameter int DW         = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_id
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t        state;
    logic          sel;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Pick the winner among the requests visible in IDLE and mux its command
    always_comb begin
        if (cpu_req && dbg_req) begin
            sel = (FIXED_PRIO != 0) ? 1'b0 : ~grant_id;
        end else begin
            sel = dbg_req && !cpu_req;
        end
        sel_we    = sel ? dbg_we    : cpu_we;
        sel_addr  = sel ? dbg_addr  : cpu_addr;
        sel_wdata = sel ? dbg_wdata : cpu_wdata;
    end

    // Access sequencer; grant_id doubles as the record of the current winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            busy      <= 1'b0;
            grant_id  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        grant_id  <= sel;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_rd    <= !sel_we;
                        mem_wr    <= sel_we;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    if (mem_rd) begin
                        if (grant_id) begin
                            dbg_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                    cpu_ack <= !grant_id;
                    dbg_ack <= grant_id;
                    state   <= ACK;
                end
                ACK: begin
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
